// File: rtl/mpeg2_pkg.sv
// mpeg2_pkg: MPEG-2 scan tables (raster address per scan position) and zigzag_rle state encodings
package mpeg2_pkg;
  localparam logic [5:0] SCAN_ZIGZAG [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
  localparam logic [5:0] SCAN_ALT [0:63] = '{
    6'd0,  6'd8,  6'd16, 6'd24, 6'd1,  6'd9,  6'd2,  6'd10,
    6'd17, 6'd25, 6'd32, 6'd40, 6'd48, 6'd56, 6'd57, 6'd49,
    6'd41, 6'd33, 6'd26, 6'd18, 6'd3,  6'd11, 6'd4,  6'd12,
    6'd19, 6'd27, 6'd34, 6'd42, 6'd50, 6'd58, 6'd35, 6'd43,
    6'd51, 6'd59, 6'd20, 6'd28, 6'd5,  6'd13, 6'd6,  6'd14,
    6'd21, 6'd29, 6'd36, 6'd44, 6'd52, 6'd60, 6'd37, 6'd45,
    6'd53, 6'd61, 6'd22, 6'd30, 6'd7,  6'd15, 6'd23, 6'd31,
    6'd38, 6'd46, 6'd54, 6'd62, 6'd39, 6'd47, 6'd55, 6'd63};
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_EOB   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    PRIME = ST_PRIME,
    SCAN  = ST_SCAN,
    EOB   = ST_EOB,
    DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/scan_lut.sv
// scan_lut: scan position idx -> raster address; alt selects alternate scan (1) or zigzag (0)
module scan_lut
  import mpeg2_pkg::*;
(
  input  logic [5:0] idx,
  input  logic       alt,
  output logic [5:0] addr
);
  assign addr = alt ? SCAN_ALT[idx] : SCAN_ZIGZAG[idx];
endmodule

// File: rtl/zigzag_rle.sv
// zigzag_rle: scan 64 coeffs from sync RAM (raddr/rq), emit (orun,olevel) then EOB on ovalid/oready; rdy/en start
module zigzag_rle
  import mpeg2_pkg::*;
#(
  parameter int DC_SEPARATE = 1,
  parameter int RUN_W       = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    rdy,
  input  logic                    en,
  input  logic                    alt_scan,
  output logic [5:0]              raddr,
  input  logic signed [15:0]      rq,
  output logic                    ovalid,
  input  logic                    oready,
  output logic [RUN_W-1:0]        orun,
  output logic signed [15:0]      olevel,
  output logic                    oeob
);
  state_t state;
  logic [5:0] idx;
  logic [RUN_W-1:0] run;
  logic alt_q;
  logic hold_v;
  logic signed [15:0] hold_q;
  logic signed [15:0] cur;
  logic [6:0] nxt;
  logic [5:0] lut_idx, lut_addr;
  logic is_zero, slot_free, advance;
  assign cur = hold_v ? hold_q : rq;
  assign is_zero = cur == 16'sd0 && !(DC_SEPARATE != 0 && idx == 6'd0);
  assign slot_free = !ovalid || oready;
  assign advance = is_zero || slot_free;
  assign nxt = {1'b0, idx} + 7'd2;
  assign lut_idx = state == IDLE ? 6'd0 : state == PRIME ? 6'd1 : nxt[6] ? 6'd63 : nxt[5:0];
  scan_lut u_lut (
    .idx  (lut_idx),
    .alt  (state == IDLE ? alt_scan : alt_q),
    .addr (lut_addr)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      raddr  <= '0;
      ovalid <= 1'b0;
      orun   <= '0;
      olevel <= '0;
      oeob   <= 1'b0;
      idx    <= '0;
      run    <= '0;
      alt_q  <= 1'b0;
      hold_v <= 1'b0;
      hold_q <= '0;
    end else begin
      if (ovalid && oready) ovalid <= 1'b0;
      case (state)
        IDLE: if (en) begin
          alt_q <= alt_scan;
          idx   <= '0;
          run   <= '0;
          raddr <= lut_addr;
          rdy   <= 1'b0;
          state <= PRIME;
        end
        PRIME: begin
          raddr <= lut_addr;
          state <= SCAN;
        end
        SCAN: if (advance) begin
          idx    <= idx + 6'd1;
          raddr  <= lut_addr;
          hold_v <= 1'b0;
          if (is_zero) run <= run + RUN_W'(run != '1);
          else begin
            orun   <= run;
            olevel <= cur;
            oeob   <= 1'b0;
            ovalid <= 1'b1;
            run    <= '0;
          end
          if (idx == 6'd63) state <= EOB;
        end else begin
          hold_v <= 1'b1;
          hold_q <= cur;
        end
        EOB: begin
          raddr <= '0;
          if (slot_free) begin
            oeob   <= 1'b1;
            orun   <= '0;
            olevel <= '0;
            ovalid <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: if (ovalid && oready) begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zigzag_rle.sv
// tb_zigzag_rle: table-driven check of zigzag_rle with a sync RAM model, two instances (DC_SEPARATE 1 and 0)
module tb_zigzag_rle;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, alt_scan = 1'b0, oready = 1'b1, sel = 1'b1;
  always #5 clk = ~clk;
  logic signed [15:0] mem [64];
  logic [5:0] raddr0, raddr1;
  logic signed [15:0] rq0, rq1, olevel0, olevel1, olevel;
  logic rdy0, rdy1, ovalid0, ovalid1, oeob0, oeob1, rdy, ovalid, oeob;
  logic [5:0] orun0, orun1, orun, raddr;
  always @(posedge clk) begin
    rq0 <= mem[raddr0];
    rq1 <= mem[raddr1];
  end
  zigzag_rle #(.DC_SEPARATE(1), .RUN_W(6)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rdy(rdy1), .en(en), .alt_scan(alt_scan), .raddr(raddr1), .rq(rq1),
    .ovalid(ovalid1), .oready(oready), .orun(orun1), .olevel(olevel1), .oeob(oeob1));
  zigzag_rle #(.DC_SEPARATE(0), .RUN_W(6)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .rdy(rdy0), .en(en), .alt_scan(alt_scan), .raddr(raddr0), .rq(rq0),
    .ovalid(ovalid0), .oready(oready), .orun(orun0), .olevel(olevel0), .oeob(oeob0));
  assign rdy    = sel ? rdy1 : rdy0;
  assign raddr  = sel ? raddr1 : raddr0;
  assign ovalid = sel ? ovalid1 : ovalid0;
  assign orun   = sel ? orun1 : orun0;
  assign olevel = sel ? olevel1 : olevel0;
  assign oeob   = sel ? oeob1 : oeob0;
  typedef struct {
    logic alt;
    logic dc;
    int   pat;
    int   n;
    int   run [4];
    int   lvl [4];
  } vec_t;
  vec_t vecs [7];
  int zz [64];
  int tests = 0, fails = 0;
  int q_run [$];
  int q_lvl [$];
  int eob_n, first_c, eob_c, rdy_c;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic set_vec(input int i, input logic alt, input logic dc, input int pat, input int n,
                         input int r0, input int l0, input int r1, input int l1,
                         input int r2, input int l2, input int r3, input int l3);
    vecs[i].alt = alt; vecs[i].dc = dc; vecs[i].pat = pat; vecs[i].n = n;
    vecs[i].run[0] = r0; vecs[i].run[1] = r1; vecs[i].run[2] = r2; vecs[i].run[3] = r3;
    vecs[i].lvl[0] = l0; vecs[i].lvl[1] = l1; vecs[i].lvl[2] = l2; vecs[i].lvl[3] = l3;
  endtask
  task automatic load(input int pat);
    for (int i = 0; i < 64; i++) mem[i] = (pat == 4) ? 16'(i + 1) : 16'sd0;
    if (pat == 0) mem[0] = 16'sd100;
    if (pat == 1) begin
      mem[0] = 16'sd5; mem[1] = -16'sd3; mem[8] = 16'sd7; mem[63] = 16'sd1;
    end
    if (pat == 3) mem[63] = -16'sd1;
  endtask
  task automatic run_block(input logic alt, input bit tog);
    int c;
    bit done, pv, pr;
    int prun, plvl;
    q_run.delete(); q_lvl.delete();
    eob_n = 0; first_c = -1; eob_c = -1; rdy_c = -1;
    oready = 1'b1;
    c = 0;
    while (!(rdy0 && rdy1) && c < 200) begin
      @(negedge clk); c++;
    end
    check("idle_wait", int'(c < 200), 1);
    en = 1'b1; alt_scan = alt;
    @(negedge clk);
    en = 1'b0;
    c = 0; done = 0; pv = 0; pr = 1; prun = 0; plvl = 0;
    while (rdy_c < 0 && c < 300) begin
      @(negedge clk); c++;
      if (pv && !pr) begin
        check("hold_valid", int'(ovalid), 1);
        check("hold_run", int'(orun), prun);
        check("hold_lvl", int'(olevel), plvl);
      end
      if (c == 1) check("busy_rdy", int'(rdy), 0);
      if (ovalid && first_c < 0) first_c = c;
      if (ovalid && oeob && eob_c < 0) eob_c = c;
      if (done && rdy) rdy_c = c;
      oready = tog ? (c % 2 == 1) : 1'b1;
      if (ovalid && oready && !done) begin
        if (oeob) begin
          eob_n++;
          done = 1;
        end else begin
          q_run.push_back(int'(orun));
          q_lvl.push_back(int'(olevel));
        end
      end
      pv = ovalid; pr = oready; prun = int'(orun); plvl = int'(olevel);
    end
    oready = 1'b1;
    check("block_timeout", int'(c < 300), 1);
    check("eob_count", eob_n, 1);
  endtask
  task automatic check_full_zigzag(input string tag);
    check({tag, "_n"}, q_run.size(), 64);
    for (int k = 0; k < 64 && k < q_run.size(); k++) begin
      check($sformatf("%s_run%0d", tag, k), q_run[k], 0);
      check($sformatf("%s_lvl%0d", tag, k), q_lvl[k], zz[k] + 1);
    end
  endtask
  initial begin
    zz = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
           12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
           35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
           58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    set_vec(0, 0, 1, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    set_vec(1, 0, 1, 1, 4, 0, 5, 0, -3, 0, 7, 60, 1);
    set_vec(2, 1, 1, 1, 4, 0, 5, 0, 7, 2, -3, 58, 1);
    set_vec(3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(4, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(5, 0, 0, 3, 1, 63, -1, 0, 0, 0, 0, 0, 0);
    set_vec(6, 0, 1, 3, 2, 0, 0, 62, -1, 0, 0, 0, 0);
    load(2);
    repeat (2) @(negedge clk);
    check("rst_rdy", int'(rdy), 1);
    check("rst_raddr", int'(raddr), 0);
    check("rst_ovalid", int'(ovalid), 0);
    check("rst_orun", int'(orun), 0);
    check("rst_olevel", int'(olevel), 0);
    check("rst_oeob", int'(oeob), 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].dc;
      load(vecs[i].pat);
      run_block(vecs[i].alt, 0);
      check($sformatf("v%0d_n", i), q_run.size(), vecs[i].n);
      for (int k = 0; k < vecs[i].n && k < q_run.size(); k++) begin
        check($sformatf("v%0d_run%0d", i, k), q_run[k], vecs[i].run[k]);
        check($sformatf("v%0d_lvl%0d", i, k), q_lvl[k], vecs[i].lvl[k]);
      end
      if (i == 0) begin
        check("lat_first", first_c, 2);
        check("lat_eob", eob_c, 66);
        check("lat_rdy", rdy_c, 67);
      end
    end
    sel = 1'b1;
    load(4);
    run_block(1'b0, 1'b1);
    check_full_zigzag("tog");
    en = 1'b1; alt_scan = 1'b0;
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_valid", int'(ovalid), 1);
    reset_n = 1'b0;
    #1;
    check("arst_ovalid", int'(ovalid), 0);
    check("arst_rdy", int'(rdy), 1);
    check("arst_raddr", int'(raddr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_block(1'b0, 1'b0);
    check_full_zigzag("after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
